// File: rtl/player_move_ctrl_if.sv
// Purpose: bundles the button enables, tile-map read port, bomb handshake and
//          player status outputs of player_move_ctrl into one port.
// Ports:   slave modport = controller side (enables/tile response/bomb_done in,
//          read request/position/pulses out); master modport = the opposite side.
interface player_move_ctrl_if;
  // debounced one-cycle button enables
  logic       left_scen;
  logic       right_scen;
  logic       up_scen;
  logic       down_scen;
  logic       mid_scen;
  // tile map read port
  logic       tile_rd_req;
  logic [3:0] tile_rd_x;
  logic [3:0] tile_rd_y;
  logic       tile_rd_valid;
  logic [1:0] tile_rd_data;
  // bomb / explosion handshake
  logic       bomb_done;
  logic       bomb_place;
  logic [3:0] bomb_x;
  logic [3:0] bomb_y;
  logic [2:0] bombs_active;
  // player status
  logic [3:0] player_x;
  logic [3:0] player_y;
  logic       busy;
  logic       move_done;
  logic       move_blocked;

  modport slave (
    input  left_scen, right_scen, up_scen, down_scen, mid_scen,
    input  tile_rd_valid, tile_rd_data, bomb_done,
    output tile_rd_req, tile_rd_x, tile_rd_y,
    output bomb_place, bomb_x, bomb_y, bombs_active,
    output player_x, player_y, busy, move_done, move_blocked
  );

  modport master (
    output left_scen, right_scen, up_scen, down_scen, mid_scen,
    output tile_rd_valid, tile_rd_data, bomb_done,
    input  tile_rd_req, tile_rd_x, tile_rd_y,
    input  bomb_place, bomb_x, bomb_y, bombs_active,
    input  player_x, player_y, busy, move_done, move_blocked
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Purpose: turns button enables into grid moves (checked against the tile map)
//          and bomb drops; owns the player position and the live-bomb count.
// Ports:   CLK, RESET (sync, active high), bus (player_move_ctrl_if.slave).
// Latency: enable -> read request next cycle; valid at cycle k -> move_done and
//          new position at k+1; out-of-grid moves blocked the cycle after enable.
//          Bomb drop visible the cycle after mid_scen, independent of moves.
module player_move_ctrl #(
  parameter int GRID_W    = 15,
  parameter int GRID_H    = 13,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int MAX_BOMBS = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  player_move_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        pos_x_q, pos_x_d;
  logic [3:0]        pos_y_q, pos_y_d;
  logic [3:0]        rd_x_q, rd_x_d;
  logic [3:0]        rd_y_q, rd_y_d;
  logic              rd_req_q, rd_req_d;
  logic              done_q, done_d;
  logic              blk_q, blk_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              place_q, place_d;
  logic [3:0]        bomb_x_q, bomb_x_d;
  logic [3:0]        bomb_y_q, bomb_y_d;
  logic [2:0]        bombs_q, bombs_d;

  // Move decode: one direction wins (up > down > left > right). Bounds are
  // tested on the current coordinate, so the +/-1 result never wraps into use.
  logic       mv_req;
  logic       tgt_ok;
  logic [3:0] tgt_x;
  logic [3:0] tgt_y;

  always_comb begin
    mv_req = bus.up_scen | bus.down_scen | bus.left_scen | bus.right_scen;
    tgt_x  = pos_x_q;
    tgt_y  = pos_y_q;
    tgt_ok = 1'b0;
    if (bus.up_scen) begin
      tgt_y  = pos_y_q - 4'd1;
      tgt_ok = (pos_y_q != 4'd0);
    end else if (bus.down_scen) begin
      tgt_y  = pos_y_q + 4'd1;
      tgt_ok = (32'(pos_y_q) < 32'(GRID_H - 1));
    end else if (bus.left_scen) begin
      tgt_x  = pos_x_q - 4'd1;
      tgt_ok = (pos_x_q != 4'd0);
    end else if (bus.right_scen) begin
      tgt_x  = pos_x_q + 4'd1;
      tgt_ok = (32'(pos_x_q) < 32'(GRID_W - 1));
    end
  end

  // Move FSM next state and registered outputs.
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    rd_x_d   = rd_x_q;
    rd_y_d   = rd_y_q;
    rd_req_d = rd_req_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    blk_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Enables seen while not IDLE fall through here and are simply lost.
        if (mv_req) begin
          if (tgt_ok) begin
            state_d  = LOOKUP;
            rd_req_d = 1'b1;
            rd_x_d   = tgt_x;
            rd_y_d   = tgt_y;
            wait_d   = '0;
          end else begin
            blk_d = 1'b1;
          end
        end
      end

      LOOKUP: begin
        // The read address registers double as the move target.
        if (bus.tile_rd_valid) begin
          rd_req_d = 1'b0;
          if (bus.tile_rd_data == 2'd0) begin
            // Position and move_done are loaded on entry so both are visible
            // during the COMMIT cycle itself.
            state_d = COMMIT;
            pos_x_d = rd_x_q;
            pos_y_d = rd_y_q;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            blk_d   = 1'b1;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // TIMEOUT cycles of request without a response: treat as a wall.
          state_d  = IDLE;
          rd_req_d = 1'b0;
          blk_d    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Bomb path runs in every state. It samples the registered position, so a
  // move committing in the same cycle still drops the bomb on the old tile.
  logic bomb_drop;
  logic bomb_free;

  always_comb begin
    bomb_drop = bus.mid_scen  && (bombs_q < 3'(MAX_BOMBS));
    bomb_free = bus.bomb_done && (bombs_q != 3'd0);
    place_d   = bomb_drop;
    bomb_x_d  = bomb_x_q;
    bomb_y_d  = bomb_y_q;
    bombs_d   = bombs_q;
    if (bomb_drop) begin
      bomb_x_d = pos_x_q;
      bomb_y_d = pos_y_q;
    end
    if (bomb_drop && !bomb_free) begin
      bombs_d = bombs_q + 3'd1;
    end else if (bomb_free && !bomb_drop) begin
      bombs_d = bombs_q - 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      pos_x_q  <= 4'(START_X);
      pos_y_q  <= 4'(START_Y);
      rd_x_q   <= 4'd0;
      rd_y_q   <= 4'd0;
      rd_req_q <= 1'b0;
      wait_q   <= '0;
      done_q   <= 1'b0;
      blk_q    <= 1'b0;
      place_q  <= 1'b0;
      bomb_x_q <= 4'd0;
      bomb_y_q <= 4'd0;
      bombs_q  <= 3'd0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      rd_x_q   <= rd_x_d;
      rd_y_q   <= rd_y_d;
      rd_req_q <= rd_req_d;
      wait_q   <= wait_d;
      done_q   <= done_d;
      blk_q    <= blk_d;
      place_q  <= place_d;
      bomb_x_q <= bomb_x_d;
      bomb_y_q <= bomb_y_d;
      bombs_q  <= bombs_d;
    end
  end

  assign bus.tile_rd_req  = rd_req_q;
  assign bus.tile_rd_x    = rd_x_q;
  assign bus.tile_rd_y    = rd_y_q;
  assign bus.player_x     = pos_x_q;
  assign bus.player_y     = pos_y_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.move_done    = done_q;
  assign bus.move_blocked = blk_q;
  assign bus.bomb_place   = place_q;
  assign bus.bomb_x       = bomb_x_q;
  assign bus.bomb_y       = bomb_y_q;
  assign bus.bombs_active = bombs_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Purpose: directed plus randomized check of player_move_ctrl against a
//          coordinate/bomb-count reference model kept in the bench.
// Ports:   none (top-level bench); drives the DUT through player_move_ctrl_if.
module tb_player_move_ctrl;

  localparam int GRID_W    = 15;
  localparam int GRID_H    = 13;
  localparam int MAX_BOMBS = 3;
  localparam int TIMEOUT   = 15;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  player_move_ctrl_if bus ();

  player_move_ctrl #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(1), .START_Y(1),
    .MAX_BOMBS(MAX_BOMBS), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int px, py, nb, bx, by;

  // monitors: read requests started and move_done pulses seen
  int   rd_starts = 0;
  int   done_seen = 0;
  logic req_prev  = 1'b0;
  always @(negedge CLK) begin
    if (bus.tile_rd_req && !req_prev) rd_starts++;
    if (bus.move_done) done_seen++;
    req_prev = bus.tile_rd_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_in();
    bus.left_scen     = 1'b0;
    bus.right_scen    = 1'b0;
    bus.up_scen       = 1'b0;
    bus.down_scen     = 1'b0;
    bus.mid_scen      = 1'b0;
    bus.tile_rd_valid = 1'b0;
    bus.tile_rd_data  = 2'd0;
    bus.bomb_done     = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_in();
    step();
    step();
    RESET = 1'b0;
    px = 1; py = 1; nb = 0; bx = 0; by = 0;
  endtask

  // 0 up, 1 down, 2 left, 3 right
  task automatic set_dir(input int dir, input logic v);
    case (dir)
      0:       bus.up_scen    = v;
      1:       bus.down_scen  = v;
      2:       bus.left_scen  = v;
      default: bus.right_scen = v;
    endcase
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, ".x"}, 32'(bus.player_x), 32'(px));
    chk({tag, ".y"}, 32'(bus.player_y), 32'(py));
  endtask

  // One complete move attempt. The tile map answers dly cycles after the
  // request first appears, or never if never_ans is set.
  task automatic do_move(input int dir, input int dly, input logic [1:0] dat,
                         input bit never_ans, input string tag);
    int tx, ty;
    bit oob;
    tx = px;
    ty = py;
    case (dir)
      0:       ty = py - 1;
      1:       ty = py + 1;
      2:       tx = px - 1;
      default: tx = px + 1;
    endcase
    oob = (tx < 0) || (tx >= GRID_W) || (ty < 0) || (ty >= GRID_H);
    set_dir(dir, 1'b1);
    step();
    set_dir(dir, 1'b0);
    if (oob) begin
      chk({tag, ".oob_blk"}, 32'(bus.move_blocked), 1);
      chk({tag, ".oob_req"}, 32'(bus.tile_rd_req), 0);
      chk({tag, ".oob_busy"}, 32'(bus.busy), 0);
      chk_pos({tag, ".oob_pos"});
      return;
    end
    chk({tag, ".req"}, 32'(bus.tile_rd_req), 1);
    chk({tag, ".rd_x"}, 32'(bus.tile_rd_x), 32'(tx));
    chk({tag, ".rd_y"}, 32'(bus.tile_rd_y), 32'(ty));
    chk({tag, ".busy"}, 32'(bus.busy), 1);
    if (never_ans) begin
      for (int i = 0; i < TIMEOUT - 1; i++) begin
        step();
        chk({tag, ".to_req"}, 32'(bus.tile_rd_req), 1);
      end
      step();
      chk({tag, ".to_blk"}, 32'(bus.move_blocked), 1);
      chk({tag, ".to_req_low"}, 32'(bus.tile_rd_req), 0);
      chk({tag, ".to_busy"}, 32'(bus.busy), 0);
      chk_pos({tag, ".to_pos"});
      return;
    end
    for (int i = 0; i < dly; i++) begin
      step();
      chk({tag, ".hold_req"}, 32'(bus.tile_rd_req), 1);
      chk({tag, ".hold_x"}, 32'(bus.tile_rd_x), 32'(tx));
    end
    bus.tile_rd_valid = 1'b1;
    bus.tile_rd_data  = dat;
    step();
    bus.tile_rd_valid = 1'b0;
    bus.tile_rd_data  = 2'd0;
    chk({tag, ".req_drop"}, 32'(bus.tile_rd_req), 0);
    if (dat == 2'd0) begin
      px = tx;
      py = ty;
      chk({tag, ".done"}, 32'(bus.move_done), 1);
      chk({tag, ".no_blk"}, 32'(bus.move_blocked), 0);
      chk({tag, ".commit_busy"}, 32'(bus.busy), 1);
      chk_pos({tag, ".new_pos"});
      step();
      chk({tag, ".idle"}, 32'(bus.busy), 0);
      chk({tag, ".done_1cyc"}, 32'(bus.move_done), 0);
    end else begin
      chk({tag, ".blk"}, 32'(bus.move_blocked), 1);
      chk({tag, ".no_done"}, 32'(bus.move_done), 0);
      chk({tag, ".blk_busy"}, 32'(bus.busy), 0);
      chk_pos({tag, ".kept_pos"});
    end
  endtask

  // One cycle of bomb inputs with the model's expected reaction.
  task automatic bomb_cycle(input logic mid, input logic dn, input string tag);
    bit drop, freed;
    drop  = mid && (nb < MAX_BOMBS);
    freed = dn && (nb > 0);
    bus.mid_scen  = mid;
    bus.bomb_done = dn;
    step();
    bus.mid_scen  = 1'b0;
    bus.bomb_done = 1'b0;
    nb = nb + int'(drop) - int'(freed);
    if (drop) begin
      bx = px;
      by = py;
    end
    chk({tag, ".place"}, 32'(bus.bomb_place), 32'(drop));
    chk({tag, ".active"}, 32'(bus.bombs_active), 32'(nb));
    chk({tag, ".bx"}, 32'(bus.bomb_x), 32'(bx));
    chk({tag, ".by"}, 32'(bus.bomb_y), 32'(by));
  endtask

  initial begin
    int rd0, dn0;
    int r;
    RESET = 1'b1;
    clear_in();
    @(negedge CLK);
    do_reset();

    // reset state
    chk_pos("rst_pos");
    chk("rst_req", 32'(bus.tile_rd_req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdx", 32'(bus.tile_rd_x), 0);
    chk("rst_rdy", 32'(bus.tile_rd_y), 0);
    chk("rst_bombs", 32'(bus.bombs_active), 0);
    chk("rst_bx", 32'(bus.bomb_x), 0);
    chk("rst_pulses", 32'({bus.move_done, bus.move_blocked, bus.bomb_place}), 0);

    // up from (1,1), empty tile answered two cycles after the request
    rd0 = rd_starts;
    do_move(0, 2, 2'd0, 1'b0, "up_first");
    chk("up_first.reads", 32'(rd_starts - rd0), 1);

    // right into wall / brick / bomb from (1,1)
    do_reset();
    for (int d = 1; d <= 3; d++) do_move(3, 1, 2'(d), 1'b0, "right_obst");

    // same-cycle up+left: only the up lookup happens
    bus.up_scen   = 1'b1;
    bus.left_scen = 1'b1;
    step();
    clear_in();
    chk("prio.rd_x", 32'(bus.tile_rd_x), 32'(px));
    chk("prio.rd_y", 32'(bus.tile_rd_y), 32'(py - 1));
    bus.tile_rd_valid = 1'b1;
    step();
    bus.tile_rd_valid = 1'b0;
    py = py - 1;
    chk_pos("prio.pos");
    step();

    // right_scen during LOOKUP is dropped
    rd0 = rd_starts;
    dn0 = done_seen;
    bus.right_scen = 1'b1;
    step();
    chk("drop.req", 32'(bus.tile_rd_req), 1);
    step();
    bus.right_scen = 1'b0;
    bus.tile_rd_valid = 1'b1;
    step();
    bus.tile_rd_valid = 1'b0;
    px = px + 1;
    for (int i = 0; i < 4; i++) step();
    chk("drop.reads", 32'(rd_starts - rd0), 1);
    chk("drop.dones", 32'(done_seen - dn0), 1);
    chk_pos("drop.pos");

    // no response at all
    do_move(1, 0, 2'd0, 1'b1, "timeout");

    // walk to (0,5) and hit the left edge, then to x=14 and the right edge
    while (px > 0) do_move(2, 0, 2'd0, 1'b0, "walk_l");
    while (py < 5) do_move(1, 0, 2'd0, 1'b0, "walk_d");
    rd0 = rd_starts;
    do_move(2, 0, 2'd0, 1'b0, "edge_left");
    chk("edge_left.reads", 32'(rd_starts - rd0), 0);
    while (px < GRID_W - 1) do_move(3, 0, 2'd0, 1'b0, "walk_r");
    rd0 = rd_starts;
    do_move(3, 0, 2'd0, 1'b0, "edge_right");
    chk("edge_right.reads", 32'(rd_starts - rd0), 0);

    // bombs at (3,3)
    do_reset();
    do_move(3, 0, 2'd0, 1'b0, "to33");
    do_move(3, 0, 2'd0, 1'b0, "to33");
    do_move(1, 0, 2'd0, 1'b0, "to33");
    do_move(1, 0, 2'd0, 1'b0, "to33");
    for (int i = 0; i < 4; i++) bomb_cycle(1'b1, 1'b0, "bomb4");
    bomb_cycle(1'b0, 1'b1, "bomb_free");
    bomb_cycle(1'b1, 1'b1, "bomb_both");
    bomb_cycle(1'b0, 1'b1, "bomb_free2");
    bomb_cycle(1'b0, 1'b1, "bomb_free3");
    bomb_cycle(1'b0, 1'b1, "bomb_at0");

    // bomb drop in the same cycle a move commits uses the old tile
    bus.down_scen = 1'b1;
    step();
    bus.down_scen = 1'b0;
    bus.tile_rd_valid = 1'b1;
    bus.mid_scen = 1'b1;
    step();
    clear_in();
    chk("commit_bomb.place", 32'(bus.bomb_place), 1);
    chk("commit_bomb.bx", 32'(bus.bomb_x), 32'(px));
    chk("commit_bomb.by", 32'(bus.bomb_y), 32'(py));
    nb = nb + 1;
    bx = px;
    by = py;
    py = py + 1;
    chk_pos("commit_bomb.pos");
    step();

    // reset in the middle of a lookup
    bus.right_scen = 1'b1;
    step();
    bus.right_scen = 1'b0;
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    px = 1; py = 1; nb = 0; bx = 0; by = 0;
    chk("midrst.req", 32'(bus.tile_rd_req), 0);
    chk("midrst.busy", 32'(bus.busy), 0);
    chk("midrst.pulses", 32'({bus.move_done, bus.move_blocked}), 0);
    chk_pos("midrst.pos");
    step();
    chk("midrst.quiet", 32'({bus.move_done, bus.move_blocked, bus.tile_rd_req}), 0);

    // randomized walk mixed with bomb traffic
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        bomb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_bomb");
      end else begin
        do_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
                ($urandom_range(0, 11) == 0), "rnd_move");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
